// File: rtl/spi_msg_master.sv
// spi_msg_master -- command/response SPI master (mode 3, MSB first).
//
// Accepts one command at a time (status, read or write of a 4-bit register
// address) and runs it as a single SS-framed SPI transfer. Frames:
//   status : 0x00, 0x00                  -> rsp_data = {24'h0, 2nd MISO byte}
//   read   : 0x80|reg, 4 x 0x00          -> rsp_data = MISO bytes 2..5
//   write  : 0xC0|reg, wdata (4 bytes)   -> rsp_data = wdata
// H = CLK_DIV clk50MHz cycles per SCLK half period. SS falls the cycle after
// accept, bit k falls at +(2k+1)H and rises at +(2k+2)H, SS rises at
// +(16N+1)H, then SS stays high for 2H cycles before cmd_ready returns.
//
// Optional feature macro: SPI_MSG_MASTER_VERIFY_EN -- every write is followed
// (after the gap) by a read-back frame of the same register; the response is
// the read-back value and rsp_err flags a mismatch with the written data.
//
// Ports:
//   clk50MHz, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op[1:0]              00/01 status, 10 read, 11 write
//   cmd_reg[3:0]             register address
//   cmd_wdata[31:0]          write data
//   rsp_valid                one-cycle pulse when SS returns high
//   rsp_data[31:0], rsp_err  response, held until the next rsp_valid
//   SCLK, MOSI, MISO, SS     SPI link (SS active-low)
module spi_msg_master #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic        clk50MHz,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_reg,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  typedef enum logic [2:0] {IDLE, SS_SETUP, SHIFT_LO, SHIFT_HI, SS_HOLD, GAP} state_t;

  localparam logic [8:0] H_LAST   = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  state_t      state_reg;
  logic [8:0]  cnt_reg;
  logic [5:0]  bit_cnt_reg;
  logic [5:0]  last_bit_reg;
  logic [39:0] tx_reg;
  logic [31:0] rx_reg;
  logic [1:0]  op_reg;
  logic [3:0]  addr_reg;
  logic [31:0] wdata_reg;
`ifdef SPI_MSG_MASTER_VERIFY_EN
  logic        verify_pending_reg;
`endif

  // Response payload for the frame that is just finishing.
  logic [31:0] frame_result;
  always_comb begin
    frame_result = rx_reg;
    if (!op_reg[1])
      frame_result = {24'h0, rx_reg[7:0]};
    else if (op_reg[0])
      frame_result = wdata_reg;
  end

  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      op_reg       <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      SCLK         <= 1'b1;
      MOSI         <= 1'b0;
      SS           <= 1'b1;
`ifdef SPI_MSG_MASTER_VERIFY_EN
      verify_pending_reg <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_reg    <= cmd_op;
            addr_reg  <= cmd_reg;
            wdata_reg <= cmd_wdata;
            // Frame is left-aligned in tx_reg; status uses only the top 16 bits.
            case (cmd_op)
              2'b11:   tx_reg <= {4'hC, cmd_reg, cmd_wdata};
              2'b10:   tx_reg <= {4'h8, cmd_reg, 32'h0};
              default: tx_reg <= 40'h0;
            endcase
            last_bit_reg <= cmd_op[1] ? 6'd39 : 6'd15;
            SS           <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= SS_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SS_SETUP: begin
          if (cnt_reg == H_LAST) begin
            cnt_reg     <= '0;
            SCLK        <= 1'b0;
            MOSI        <= tx_reg[39];
            tx_reg      <= {tx_reg[38:0], 1'b0};
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT_LO;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        SHIFT_LO: begin
          if (cnt_reg == H_LAST) begin
            cnt_reg <= '0;
            SCLK    <= 1'b1;
            rx_reg  <= {rx_reg[30:0], MISO};
            // The last bit's high phase doubles as the SS hold time.
            state_reg <= (bit_cnt_reg == last_bit_reg) ? SS_HOLD : SHIFT_HI;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        SHIFT_HI: begin
          if (cnt_reg == H_LAST) begin
            cnt_reg     <= '0;
            SCLK        <= 1'b0;
            MOSI        <= tx_reg[39];
            tx_reg      <= {tx_reg[38:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 6'd1;
            state_reg   <= SHIFT_LO;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        SS_HOLD: begin
          if (cnt_reg == H_LAST) begin
            cnt_reg   <= '0;
            SS        <= 1'b1;
            MOSI      <= 1'b0;
            state_reg <= GAP;
`ifdef SPI_MSG_MASTER_VERIFY_EN
            if (op_reg == 2'b11) begin
              // Hold the response back until the read-back frame completes.
              verify_pending_reg <= 1'b1;
            end else begin
              rsp_valid          <= 1'b1;
              rsp_data           <= frame_result;
              rsp_err            <= verify_pending_reg && (rx_reg != wdata_reg);
              verify_pending_reg <= 1'b0;
            end
`else
            rsp_valid <= 1'b1;
            rsp_data  <= frame_result;
            rsp_err   <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg <= '0;
`ifdef SPI_MSG_MASTER_VERIFY_EN
            if (verify_pending_reg) begin
              tx_reg       <= {4'h8, addr_reg, 32'h0};
              last_bit_reg <= 6'd39;
              op_reg       <= 2'b10;
              SS           <= 1'b0;
              state_reg    <= SS_SETUP;
            end else begin
              cmd_ready <= 1'b1;
              state_reg <= IDLE;
            end
`else
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
`endif
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_msg_master.sv
// Testbench for spi_msg_master: behavioural mode-3 slave, expected-response
// queue filled at issue time, and a monitor that checks each rsp_valid
// (data, err, MOSI frame contents, SS low time) plus per-cycle link rules.
module tb_spi_msg_master;

  localparam int H = 6;

  logic        clk50MHz = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_reg;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        SCLK;
  logic        MOSI;
  logic        MISO = 1'b0;
  logic        SS;

  always #10 clk50MHz = ~clk50MHz;

  spi_msg_master #(.CLK_DIV(H)) dut (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_reg  (cmd_reg),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .SS       (SS)
  );

  typedef struct {
    logic [39:0] bits;
    int          nbits;
    int          low;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          nframes;
    logic [39:0] f0;
    int          n0;
    logic [39:0] f1;
    int          n1;
  } exp_t;

  frame_t frame_q[$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     rsp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural mode-3 slave ----------------
  logic [31:0] sregs [0:15];
  logic [39:0] s_mosi = '0;
  int          s_bits = 0;
  logic [7:0]  s_cmd = '0;
  logic [31:0] s_tx = '0;
  logic        corrupt_en = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) sregs[i] = 32'h0;
    sregs[4] = 32'hDEADBEEF;
  end

  initial forever begin
    @(negedge SS);
    s_mosi = '0;
    s_bits = 0;
    s_tx   = '0;
  end

  initial forever begin
    @(posedge SCLK);
    if (SS === 1'b0) begin
      s_mosi = {s_mosi[38:0], MOSI};
      s_bits++;
      if (s_bits == 8) begin
        s_cmd = s_mosi[7:0];
        if (s_cmd == 8'h00)             s_tx = 32'h5A00_0000;
        else if (s_cmd[7:6] == 2'b10)   s_tx = sregs[s_cmd[3:0]];
        else                            s_tx = 32'h0;
      end
      if (s_bits == 40 && s_cmd[7:6] == 2'b11) begin
        if (corrupt_en && s_cmd[3:0] == 4'd1) sregs[s_cmd[3:0]] = s_mosi[31:0] ^ 32'h0000_FF00;
        else                                  sregs[s_cmd[3:0]] = s_mosi[31:0];
      end
    end
  end

  initial forever begin
    int idx;
    @(negedge SCLK);
    if (SS === 1'b0) begin
      idx = 39 - s_bits;
      MISO = (s_bits < 8) ? 1'b0 : s_tx[idx];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic mon_ss_prev = 1'b1;
  int   mon_low = 0;
  int   mon_gap = 0;
  bit   mon_have_rise = 1'b0;

  initial forever begin
    exp_t   e;
    frame_t f;
    @(negedge clk50MHz);
    if (reset === 1'b1) begin
      mon_have_rise = 1'b0;
      mon_low = 0;
    end else begin
      if (SS === 1'b0) begin
        mon_low++;
        if (mon_ss_prev === 1'b1 && mon_have_rise)
          check("ss_gap_ge_2H", 64'(mon_gap >= 2 * H), 64'd1);
        check("ready_low_in_frame", 64'(cmd_ready), 64'd0);
      end else begin
        check("idle_sclk_mosi", 64'({SCLK, MOSI}), 64'b10);
        if (mon_ss_prev === 1'b0) begin
          frame_q.push_back('{bits: s_mosi, nbits: s_bits, low: mon_low});
          mon_low = 0;
          mon_gap = 1;
          mon_have_rise = 1'b1;
        end else begin
          mon_gap++;
        end
      end
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_data=0x%0h with no response outstanding", rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          for (int k = 0; k < e.nframes; k++) begin
            if (frame_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL missing_frame: got 0 frames required %0d", e.nframes);
            end else begin
              f = frame_q.pop_front();
              check("mosi_frame", 64'(f.bits), 64'((k == 0) ? e.f0 : e.f1));
              check("frame_bits", 64'(f.nbits), 64'((k == 0) ? e.n0 : e.n1));
              check("ss_low_cycles", 64'(f.low), 64'((2 * ((k == 0) ? e.n0 : e.n1) + 1) * H));
            end
          end
        end
      end
    end
    mon_ss_prev = SS;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic err, input int nframes,
                          input logic [39:0] f0, input int n0, input logic [39:0] f1, input int n1);
    exp_q.push_back('{data: data, err: err, nframes: nframes, f0: f0, n0: n0, f1: f1, n1: n1});
  endtask

  task automatic wait_ready();
    int t;
    for (t = 0; t < 3000; t++) begin
      if (cmd_ready === 1'b1) break;
      step();
    end
    if (t == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] rg, input logic [31:0] wd);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rg;
    cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t;
    for (t = 0; t < 3000; t++) begin
      if (rsp_count >= target) break;
      step();
    end
    if (t == 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses required %0d", rsp_count, target);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int t;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_reg   = 4'h0;
    cmd_wdata = 32'h0;
    repeat (3) step();
    check("rst_ss", 64'(SS), 64'd1);
    check("rst_sclk", 64'(SCLK), 64'd1);
    check("rst_mosi", 64'(MOSI), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // status
    push_exp(32'h0000_005A, 1'b0, 1, 40'h0, 16, 40'h0, 0);
    issue(2'b00, 4'h0, 32'h0);
    wait_rsp(1);

    // write reg0 then read it back
`ifdef SPI_MSG_MASTER_VERIFY_EN
    push_exp(32'h7654_3210, 1'b0, 2, 40'hC0_7654_3210, 40, 40'h80_0000_0000, 40);
`else
    push_exp(32'h7654_3210, 1'b0, 1, 40'hC0_7654_3210, 40, 40'h0, 0);
`endif
    issue(2'b11, 4'h0, 32'h7654_3210);
    wait_rsp(2);
    push_exp(32'h7654_3210, 1'b0, 1, 40'h80_0000_0000, 40, 40'h0, 0);
    issue(2'b10, 4'h0, 32'h0);
    wait_rsp(3);

    // fixed registers
    push_exp(32'hDEAD_BEEF, 1'b0, 1, 40'h84_0000_0000, 40, 40'h0, 0);
    issue(2'b10, 4'h4, 32'h0);
    wait_rsp(4);
    push_exp(32'h0000_0000, 1'b0, 1, 40'h85_0000_0000, 40, 40'h0, 0);
    issue(2'b10, 4'h5, 32'h0);
    wait_rsp(5);

    // op 01 behaves as status
    push_exp(32'h0000_005A, 1'b0, 1, 40'h0, 16, 40'h0, 0);
    issue(2'b01, 4'h3, 32'hFFFF_FFFF);
    wait_rsp(6);

    // reg1 write
`ifdef SPI_MSG_MASTER_VERIFY_EN
    corrupt_en = 1'b1;
    push_exp(32'h0123_BA67, 1'b1, 2, 40'hC1_0123_4567, 40, 40'h81_0000_0000, 40);
    issue(2'b11, 4'h1, 32'h0123_4567);
    wait_rsp(7);
    corrupt_en = 1'b0;
    push_exp(32'h0123_BA67, 1'b0, 1, 40'h81_0000_0000, 40, 40'h0, 0);
`else
    push_exp(32'hA5A5_A5A5, 1'b0, 1, 40'hC1_A5A5_A5A5, 40, 40'h0, 0);
    issue(2'b11, 4'h1, 32'hA5A5_A5A5);
    wait_rsp(7);
    push_exp(32'hA5A5_A5A5, 1'b0, 1, 40'h81_0000_0000, 40, 40'h0, 0);
`endif
    issue(2'b10, 4'h1, 32'h0);
    wait_rsp(8);

    // reset in the middle of a write: abort, no response
    issue(2'b11, 4'h0, 32'h1122_3344);
    for (t = 0; t < 3000; t++) begin
      if (s_bits >= 20) break;
      step();
    end
    check("reached_bit20", 64'(s_bits), 64'd20);
    base = rsp_count;
    reset = 1'b1;
    step();
    check("abort_ss", 64'(SS), 64'd1);
    check("abort_sclk", 64'(SCLK), 64'd1);
    repeat (2) step();
    reset = 1'b0;
    repeat (4 * H) step();
    check("abort_no_rsp", 64'(rsp_count), 64'(base));
    push_exp(32'h0000_005A, 1'b0, 1, 40'h0, 16, 40'h0, 0);
    issue(2'b00, 4'h0, 32'h0);
    wait_rsp(base + 1);
    // aborted write must not have reached the slave
    push_exp(32'h7654_3210, 1'b0, 1, 40'h80_0000_0000, 40, 40'h0, 0);
    issue(2'b10, 4'h0, 32'h0);
    wait_rsp(base + 2);

    // back-to-back: cmd_valid held high for three commands
    base = rsp_count;
    repeat (3) push_exp(32'h0000_005A, 1'b0, 1, 40'h0, 16, 40'h0, 0);
    wait_ready();
    cmd_op    = 2'b00;
    cmd_reg   = 4'h0;
    cmd_wdata = 32'h0;
    cmd_valid = 1'b1;
    wait_rsp(base + 3);
    cmd_valid = 1'b0;
    repeat (4 * H) step();
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    check("frames_drained", 64'(frame_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
